// File: rtl/dcache_arb_pkg.sv
// dcache_arb_pkg: shared widths, priority-mode enum and lane type for the dcache array request arbiters
package dcache_arb_pkg;
  localparam int WAYS_DEF   = 8;
  localparam int ADDR_W_DEF = 12;
  typedef enum logic {PRIO_FIXED = 1'b0, PRIO_RR = 1'b1} prio_mode_e;
  typedef struct packed {
    logic [WAYS_DEF-1:0]   way_en;
    logic [ADDR_W_DEF-1:0] addr;
  } lane_t;
endpackage

// File: rtl/rr_prio_grant.sv
// rr_prio_grant: combinational one-hot grant, fixed (index 0 first) or round-robin starting after ptr
module rr_prio_grant
  import dcache_arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  prio_mode_e       mode,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] idx
);
  int j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (mode == PRIO_RR) ? (int'(ptr) + 1 + k) % N : k;
      if (gnt == '0 && req[j]) begin
        gnt[j] = 1'b1;
        idx    = SEL_W'(j);
      end
    end
  end
endmodule

// File: rtl/dcache_array_req_arb.sv
// dcache_array_req_arb: N-input data-cache array read arbiter with registered, lane-masked output stage.
// Optional per-channel saturating grant counters under DCACHE_ARB_GRANT_CNT_EN.
module dcache_array_req_arb
  import dcache_arb_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int N_LANES = 2,
  parameter int WAYS    = WAYS_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int SEL_W   = $clog2(N_IN)
) (
  input  logic                             clock,
  input  logic                             reset,
`ifdef DCACHE_ARB_GRANT_CNT_EN
  input  logic                             cnt_clr,
  output logic [N_IN*16-1:0]               grant_cnt,
`endif
  input  logic [N_IN-1:0]                  in_valid,
  output logic [N_IN-1:0]                  in_ready,
  input  logic [N_IN*N_LANES*WAYS-1:0]     in_way_en,
  input  logic [N_IN*N_LANES*ADDR_W-1:0]   in_addr,
  input  logic [N_IN*N_LANES-1:0]          in_lane_valid,
  input  logic                             prio_rr,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [N_LANES*WAYS-1:0]          out_way_en,
  output logic [N_LANES*ADDR_W-1:0]        out_addr,
  output logic [N_LANES-1:0]               out_lane_valid,
  output logic [SEL_W-1:0]                 out_chosen
);
  logic [SEL_W-1:0]          rr_ptr, g_idx;
  logic [N_IN-1:0]           gnt;
  logic                      can_load, accept;
  logic [N_LANES*WAYS-1:0]   nxt_way;
  logic [N_LANES*ADDR_W-1:0] nxt_addr;
  logic [N_LANES-1:0]        nxt_lv;
  int                        b;

  rr_prio_grant #(.N(N_IN), .SEL_W(SEL_W)) u_grant (
    .req  (in_valid),
    .ptr  (rr_ptr),
    .mode (prio_rr ? PRIO_RR : PRIO_FIXED),
    .gnt  (gnt),
    .idx  (g_idx)
  );

  assign can_load = ~out_valid | out_ready;
  assign accept   = can_load & |in_valid;
  assign in_ready = {N_IN{can_load}} & gnt;

  // Invalid lanes are zeroed so the array never sees stale way enables.
  always_comb begin
    nxt_way  = '0;
    nxt_addr = '0;
    nxt_lv   = '0;
    b        = 0;
    for (int l = 0; l < N_LANES; l++) begin
      b                           = int'(g_idx) * N_LANES + l;
      nxt_lv[l]                   = in_lane_valid[b];
      nxt_way[l*WAYS +: WAYS]     = in_lane_valid[b] ? in_way_en[b*WAYS +: WAYS] : '0;
      nxt_addr[l*ADDR_W +: ADDR_W] = in_lane_valid[b] ? in_addr[b*ADDR_W +: ADDR_W] : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid      <= 1'b0;
      out_way_en     <= '0;
      out_addr       <= '0;
      out_lane_valid <= '0;
      out_chosen     <= '0;
      rr_ptr         <= SEL_W'(N_IN - 1);
    end else if (can_load) begin
      out_valid <= |in_valid;
      if (accept) begin
        out_way_en     <= nxt_way;
        out_addr       <= nxt_addr;
        out_lane_valid <= nxt_lv;
        out_chosen     <= g_idx;
        rr_ptr         <= g_idx;
      end
    end
  end

`ifdef DCACHE_ARB_GRANT_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) grant_cnt <= '0;
    else if (cnt_clr) grant_cnt <= '0;
    else
      for (int i = 0; i < N_IN; i++)
        if (accept && gnt[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_dcache_array_req_arb.sv
// tb_dcache_array_req_arb: scoreboard bench for dcache_array_req_arb (N_IN=3, N_LANES=2, WAYS=8, ADDR_W=12)
module tb_dcache_array_req_arb;
  logic        clock = 0, reset = 0;
  logic [2:0]  in_valid = 0, in_ready;
  logic [47:0] in_way_en = 0;
  logic [71:0] in_addr = 0;
  logic [5:0]  in_lane_valid = 0;
  logic        prio_rr = 0, out_ready = 0, out_valid;
  logic [15:0] out_way_en;
  logic [23:0] out_addr;
  logic [1:0]  out_lane_valid, out_chosen;
`ifdef DCACHE_ARB_GRANT_CNT_EN
  logic        cnt_clr = 0;
  logic [47:0] grant_cnt;
`endif

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] way;
    logic [23:0] addr;
    logic [1:0]  lv;
  } exp_t;

  exp_t       q[$];
  int         n_pass = 0, n_chk = 0;
  int         m_ptr = 2;
  logic       m_ov = 0;
  logic [2:0] seen_rdy;
  int         cnt[3] = '{0, 0, 0};

  dcache_array_req_arb dut (
    .clock(clock), .reset(reset),
`ifdef DCACHE_ARB_GRANT_CNT_EN
    .cnt_clr(cnt_clr), .grant_cnt(grant_cnt),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_way_en(in_way_en), .in_addr(in_addr),
    .in_lane_valid(in_lane_valid), .prio_rr(prio_rr), .out_ready(out_ready),
    .out_valid(out_valid), .out_way_en(out_way_en), .out_addr(out_addr),
    .out_lane_valid(out_lane_valid), .out_chosen(out_chosen)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic int model_g(input logic [2:0] v, input logic rr, input int ptr);
    for (int k = 1; k <= 3; k++) begin
      int c = rr ? (ptr + k) % 3 : k - 1;
      if (v[c]) return c;
    end
    return 0;
  endfunction

  function automatic exp_t expect_for(input int c);
    exp_t e;
    e.ch = 2'(c);
    for (int l = 0; l < 2; l++) begin
      int s = c * 2 + l;
      e.lv[l]          = in_lane_valid[s];
      e.way[l*8 +: 8]  = in_lane_valid[s] ? in_way_en[s*8 +: 8] : 8'h0;
      e.addr[l*12 +: 12] = in_lane_valid[s] ? in_addr[s*12 +: 12] : 12'h0;
    end
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ov  = 0;
    m_ptr = 2;
    foreach (cnt[i]) cnt[i] = 0;
  endtask

  task automatic cycle(input logic [2:0] v, input logic rr, input logic ordy);
    logic cl;
    int   g;
    exp_t e;
    in_valid = v; prio_rr = rr; out_ready = ordy;
    #1;
    cl = !m_ov || ordy;
    g  = model_g(v, rr, m_ptr);
    seen_rdy = in_ready;
    check("in_ready", 72'(in_ready), (cl && v != 0) ? 72'(1 << g) : 72'(0));
    check("out_valid", 72'(out_valid), 72'(m_ov));
    if (m_ov) begin
      e = q[0];
      check("out_chosen", 72'(out_chosen), 72'(e.ch));
      check("out_way_en", 72'(out_way_en), 72'(e.way));
      check("out_addr", 72'(out_addr), 72'(e.addr));
      check("out_lane_valid", 72'(out_lane_valid), 72'(e.lv));
      if (ordy) void'(q.pop_front());
    end
    if (cl) begin
      if (v != 0) begin
        q.push_back(expect_for(g));
        m_ptr = g;
        m_ov  = 1;
        if (cnt[g] < 65535) cnt[g]++;
      end else m_ov = 0;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 0;
    @(negedge clock);
    reset = 1;
    model_reset();
  endtask

  initial begin
    #3;
    check("rst_out_valid", 72'(out_valid), 72'(0));
    check("rst_out_chosen", 72'(out_chosen), 72'(0));
    check("rst_out_way_en", 72'(out_way_en), 72'(0));
    check("rst_out_addr", 72'(out_addr), 72'(0));
    check("rst_out_lane_valid", 72'(out_lane_valid), 72'(0));
    @(negedge clock);
    reset = 1;
    in_way_en = 48'h0123456789AB; in_addr = 72'h0FEDCBA9876543210F; in_lane_valid = 6'h3F;
    for (int i = 0; i < 6; i++) begin
      cycle(3'b111, 0, 1);
      check("fixed_ready", 72'(seen_rdy), 72'(3'b001));
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(3'b111, 1, 1);
      check("rr_seq", 72'(seen_rdy), 72'(1 << (i % 3)));
    end
    cycle(3'b110, 1, 1);
    check("rr_wrap_a", 72'(seen_rdy), 72'(3'b010));
    cycle(3'b100, 1, 1);
    check("rr_wrap_b", 72'(seen_rdy), 72'(3'b100));
    in_way_en[32 +: 16] = 16'h0FFF;
    in_addr[48 +: 24]   = 24'h123ABC;
    in_lane_valid[5:4]  = 2'b10;
    cycle(3'b100, 0, 1);
    cycle(3'b000, 0, 0);
    check("mask_way", 72'(out_way_en), 72'(16'h0F00));
    check("mask_addr", 72'(out_addr), 72'(24'h123000));
    check("mask_lv", 72'(out_lane_valid), 72'(2'b10));
    in_lane_valid = 6'b001111;
    for (int i = 0; i < 3; i++) cycle(3'b010, 0, 0);
    cycle(3'b010, 0, 1);
    cycle(3'b000, 0, 1);
    cycle(3'b000, 0, 1);
    for (int i = 0; i < 300; i++) begin
      in_way_en = {16'($urandom()), $urandom()};
      in_addr = {8'($urandom()), $urandom(), $urandom()};
      in_lane_valid = 6'($urandom());
      cycle(3'($urandom()), 1'($urandom()), ($urandom_range(0, 3) != 0));
    end
    cycle(3'b000, 0, 1);
    cycle(3'b000, 0, 1);
`ifdef DCACHE_ARB_GRANT_CNT_EN
    for (int i = 0; i < 3; i++) check("grant_cnt", 72'(grant_cnt[i*16 +: 16]), 72'(cnt[i]));
    cnt_clr = 1;
    cycle(3'b001, 0, 1);
    cnt_clr = 0;
    foreach (cnt[i]) cnt[i] = 0;
    for (int i = 0; i < 3; i++) check("cnt_clr", 72'(grant_cnt[i*16 +: 16]), 72'(cnt[i]));
    for (int i = 0; i < 65540; i++) cycle(3'b001, 0, 1);
    check("cnt_sat", 72'(grant_cnt[15:0]), 72'(16'hFFFF));
    check("cnt_sat_model", 72'(grant_cnt[15:0]), 72'(cnt[0]));
`endif
    cycle(3'b001, 0, 1);
    cycle(3'b000, 0, 0);
    check("stall_valid", 72'(out_valid), 72'(1));
    #2 reset = 0;
    #1;
    check("async_rst_valid", 72'(out_valid), 72'(0));
    check("async_rst_chosen", 72'(out_chosen), 72'(0));
`ifdef DCACHE_ARB_GRANT_CNT_EN
    check("async_rst_cnt", 72'(grant_cnt), 72'(0));
`endif
    @(negedge clock);
    reset = 1;
    model_reset();
    cycle(3'b111, 1, 1);
    check("post_rst_rr", 72'(seen_rdy), 72'(3'b001));
    cycle(3'b000, 0, 1);
    cycle(3'b000, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
